xadac_vstore_ser: RTL and testbench

- Store-side serializer of the xadac coprocessor.
- Accepts one 128-bit vector store (VectorT, 16 ElemT lanes) per request and emits it as up to four 32-bit word writes on the core data-memory port.
- Waits for each write acknowledge, then returns a tagged completion (IdT) to the coprocessor issue stage.
- It is the write-direction counterpart of the vector load path, which assembles words into a VectorT.

---
 rtl/xadac_vstore_ser.sv | 211 +++++++++++++++++++++
 tb/tb_xadac_vstore_ser.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xadac_vstore_ser.sv
// xadac_vstore_ser: store-side serializer of the xadac coprocessor.
//
// Takes one VectorWidth-bit vector store per request and writes it to the core
// data-memory port as Beats word writes. Each write waits for its acknowledge.
// A tagged completion is then returned to the issue stage. A base address that
// is not word-aligned completes at once with an error and makes no memory
// traffic. A bus error on any ack aborts the remaining beats.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_*                 vector store request (valid/ready), lane k = data[8k+7:8k]
//   mem_req_*, mem_addr_o,
//   mem_wdata_o, mem_be_o word write request (valid/ready)
//   mem_ack_i, mem_err_i  write acknowledge plus error qualifier
//   rsp_*                 completion (valid/ready) with tag and error flag
//
// Build option:
//   XADAC_VSTORE_BEAT_SKIP_EN  when defined, beats whose byte-enable slice is
//                              zero are not issued. An all-zero mask completes
//                              with no memory traffic.

module xadac_vstore_ser #(
    parameter int unsigned AddrWidth   = 32,
    parameter int unsigned XlenWidth   = 32,
    parameter int unsigned VectorWidth = 128,
    parameter int unsigned IdWidth     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [AddrWidth-1:0]     req_addr_i,
    input  logic [VectorWidth-1:0]   req_data_i,
    input  logic [VectorWidth/8-1:0] req_mask_i,
    input  logic [IdWidth-1:0]       req_id_i,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic [XlenWidth-1:0]     mem_wdata_o,
    output logic [XlenWidth/8-1:0]   mem_be_o,
    input  logic                     mem_ack_i,
    input  logic                     mem_err_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IdWidth-1:0]       rsp_id_o,
    output logic                     rsp_err_o
);

    localparam int unsigned BeWidth   = XlenWidth / 8;
    localparam int unsigned Beats     = VectorWidth / XlenWidth;
    localparam int unsigned MaskWidth = VectorWidth / 8;
    localparam int unsigned BeatWidth = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned OffWidth  = (BeWidth > 1) ? $clog2(BeWidth) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                 state_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [VectorWidth-1:0] data_q;
    logic [MaskWidth-1:0]   mask_q;
    logic [IdWidth-1:0]     id_q;
    logic [BeatWidth-1:0]   beat_q;
    logic                   err_q;
    logic                   req_ready_q;
    logic                   mem_req_valid_q;
    logic [AddrWidth-1:0]   mem_addr_q;
    logic [XlenWidth-1:0]   mem_wdata_q;
    logic [BeWidth-1:0]     mem_be_q;
    logic                   rsp_valid_q;

    logic [BeatWidth-1:0]   first_beat, next_beat, sel_beat;
    logic                   first_found, next_found;
    logic [AddrWidth-1:0]   sel_base, sel_addr;
    logic [VectorWidth-1:0] sel_data;
    logic [MaskWidth-1:0]   sel_mask;
    logic [XlenWidth-1:0]   sel_wdata;
    logic [BeWidth-1:0]     sel_be;
    logic                   misaligned;

    assign misaligned = (req_addr_i[OffWidth-1:0] != '0);

`ifdef XADAC_VSTORE_BEAT_SKIP_EN
    // Lowest nonzero slice wins; scanning downwards lets the last hit stand.
    always_comb begin
        first_found = 1'b0;
        first_beat  = '0;
        next_found  = 1'b0;
        next_beat   = '0;
        for (int b = Beats - 1; b >= 0; b--) begin
            if (req_mask_i[b*BeWidth +: BeWidth] != '0) begin
                first_found = 1'b1;
                first_beat  = BeatWidth'(b);
            end
            if (b > int'(beat_q) && mask_q[b*BeWidth +: BeWidth] != '0) begin
                next_found = 1'b1;
                next_beat  = BeatWidth'(b);
            end
        end
    end
`else
    assign first_found = 1'b1;
    assign first_beat  = '0;
    assign next_found  = (beat_q != BeatWidth'(Beats - 1));
    assign next_beat   = beat_q + 1'b1;
`endif

    // Word for the next ISSUE: taken from the request ports on accept and
    // from the held copy on a WAIT ack. This keeps the first write at cycle 1.
    always_comb begin
        if (state_q == StIdle) begin
            sel_base = req_addr_i;
            sel_data = req_data_i;
            sel_mask = req_mask_i;
            sel_beat = first_beat;
        end else begin
            sel_base = addr_q;
            sel_data = data_q;
            sel_mask = mask_q;
            sel_beat = next_beat;
        end
        sel_addr  = sel_base + (AddrWidth'(sel_beat) * AddrWidth'(BeWidth));
        sel_wdata = sel_data[sel_beat*XlenWidth +: XlenWidth];
        sel_be    = sel_mask[sel_beat*BeWidth +: BeWidth];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            data_q          <= '0;
            mask_q          <= '0;
            id_q            <= '0;
            beat_q          <= '0;
            err_q           <= 1'b0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_be_q        <= '0;
            rsp_valid_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        data_q      <= req_data_i;
                        mask_q      <= req_mask_i;
                        id_q        <= req_id_i;
                        beat_q      <= first_beat;
                        err_q       <= misaligned;
                        req_ready_q <= 1'b0;
                        if (misaligned || !first_found) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            mem_req_valid_q <= 1'b1;
                            mem_addr_q      <= sel_addr;
                            mem_wdata_q     <= sel_wdata;
                            mem_be_q        <= sel_be;
                            state_q         <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    // Any ack seen here is a protocol violation and is ignored.
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= StWait;
                    end
                end
                StWait: begin
                    if (mem_ack_i) begin
                        if (mem_err_i) begin
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else if (!next_found) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end else begin
                            beat_q          <= next_beat;
                            mem_req_valid_q <= 1'b1;
                            mem_addr_q      <= sel_addr;
                            mem_wdata_q     <= sel_wdata;
                            mem_be_q        <= sel_be;
                            state_q         <= StIssue;
                        end
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o     = req_ready_q;
    assign mem_req_valid_o = mem_req_valid_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_be_o        = mem_be_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_id_o        = id_q;
    assign rsp_err_o       = err_q;

endmodule

// File: tb/tb_xadac_vstore_ser.sv
// Testbench for xadac_vstore_ser: table of store vectors with hand-computed
// expected word writes, completion tag/error and completion cycle, plus a
// hand-written reset-during-WAIT sequence.

module tb_xadac_vstore_ser;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [31:0]  req_addr_i;
    logic [127:0] req_data_i;
    logic [15:0]  req_mask_i;
    logic [3:0]   req_id_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i;
    logic [31:0]  mem_addr_o;
    logic [31:0]  mem_wdata_o;
    logic [3:0]   mem_be_o;
    logic         mem_ack_i;
    logic         mem_err_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [3:0]   rsp_id_o;
    logic         rsp_err_o;

    always #5 clk = ~clk;

    xadac_vstore_ser dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .req_mask_i      (req_mask_i),
        .req_id_i        (req_id_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_be_o        (mem_be_o),
        .mem_ack_i       (mem_ack_i),
        .mem_err_i       (mem_err_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .rsp_id_o        (rsp_id_o),
        .rsp_err_o       (rsp_err_o)
    );

    typedef struct {
        logic [31:0]      addr;
        logic [127:0]     data;
        logic [15:0]      mask;
        logic [3:0]       id;
        int               err_idx;    // write index whose ack carries mem_err_i, -1 none
        int               stall_idx;  // write index held off by mem_req_ready_i
        int               stall_n;
        int               rsp_stall;
        int               n_wr;
        logic [3:0][31:0] wa;
        logic [3:0][31:0] wd;
        logic [3:0][3:0]  wb;
        logic             exp_err;
        int               rsp_cyc;    // first cycle with rsp_valid_o, accept = cycle 0
    } vec_t;

    localparam int NVec = 8;
    localparam logic [127:0] DatA = 128'h33333333_22222222_11111111_00000000;
    localparam logic [127:0] DatB = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    vec_t vecs[NVec];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cur    = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %0h, expected %0h", cur, name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] a, input logic [127:0] d,
                           input logic [15:0] m, input logic [3:0] id, input int err_idx,
                           input int stall_idx, input int stall_n, input int rsp_stall,
                           input logic exp_err, input int rsp_cyc);
        vecs[i].addr      = a;
        vecs[i].data      = d;
        vecs[i].mask      = m;
        vecs[i].id        = id;
        vecs[i].err_idx   = err_idx;
        vecs[i].stall_idx = stall_idx;
        vecs[i].stall_n   = stall_n;
        vecs[i].rsp_stall = rsp_stall;
        vecs[i].n_wr      = 0;
        vecs[i].wa        = '0;
        vecs[i].wd        = '0;
        vecs[i].wb        = '0;
        vecs[i].exp_err   = exp_err;
        vecs[i].rsp_cyc   = rsp_cyc;
    endtask

    task automatic add_wr(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b);
        vecs[i].wa[vecs[i].n_wr] = a;
        vecs[i].wd[vecs[i].n_wr] = d;
        vecs[i].wb[vecs[i].n_wr] = b;
        vecs[i].n_wr++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1);
        chk({tag, "_mem_valid"}, mem_req_valid_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
        chk({tag, "_mem_be"}, mem_be_o, 0);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_rsp_id"}, rsp_id_o, 0);
        chk({tag, "_rsp_err"}, rsp_err_o, 0);
    endtask

    // Called at #1 after a rising edge with the DUT idle. Acts as a memory
    // that acks one cycle after each write handshake.
    task automatic run_vec(input int i);
        vec_t v;
        int   cyc, wr, stall_left, rsp_left;
        bit   ack_next, ack_err, seen_rsp, done;
        v          = vecs[i];
        cur        = i;
        wr         = 0;
        stall_left = v.stall_n;
        rsp_left   = v.rsp_stall;
        ack_next   = 1'b0;
        ack_err    = 1'b0;
        seen_rsp   = 1'b0;
        done       = 1'b0;
        chk("idle_ready", req_ready_o, 1);
        req_valid_i     = 1'b1;
        req_addr_i      = v.addr;
        req_data_i      = v.data;
        req_mask_i      = v.mask;
        req_id_i        = v.id;
        mem_req_ready_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        cyc = 1;
        while (!done && cyc < 200) begin
            mem_ack_i = ack_next;
            mem_err_i = ack_next & ack_err;
            ack_next  = 1'b0;
            chk("busy_not_ready", req_ready_o, 0);
            if (mem_req_valid_o) begin
                chk("no_extra_write", wr < v.n_wr, 1);
                if (wr < v.n_wr) begin
                    chk($sformatf("wr%0d_addr", wr), mem_addr_o, v.wa[wr]);
                    chk($sformatf("wr%0d_data", wr), mem_wdata_o, v.wd[wr]);
                    chk($sformatf("wr%0d_be", wr), mem_be_o, v.wb[wr]);
                end
                if (wr == v.stall_idx && stall_left > 0) begin
                    mem_req_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    mem_req_ready_i = 1'b1;
                    ack_next        = 1'b1;
                    ack_err         = (wr == v.err_idx);
                    wr++;
                end
            end else begin
                mem_req_ready_i = 1'b1;
            end
            if (rsp_valid_o) begin
                if (!seen_rsp) begin
                    seen_rsp = 1'b1;
                    chk("rsp_cycle", cyc, v.rsp_cyc);
                    chk("write_count", wr, v.n_wr);
                end
                chk("rsp_id", rsp_id_o, v.id);
                chk("rsp_err", rsp_err_o, v.exp_err);
                if (rsp_left > 0) begin
                    rsp_ready_i = 1'b0;
                    rsp_left--;
                end else begin
                    rsp_ready_i = 1'b1;
                    done        = 1'b1;
                end
            end else begin
                if (seen_rsp) chk("rsp_held", rsp_valid_o, 1);
                rsp_ready_i = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("completed", done, 1);
        rsp_ready_i = 1'b0;
        mem_ack_i   = 1'b0;
        mem_err_i   = 1'b0;
        chk("back_idle_ready", req_ready_o, 1);
        chk("back_idle_rsp", rsp_valid_o, 0);
        chk("back_idle_mem", mem_req_valid_o, 0);
    endtask

    initial begin
        // Vector table.
        set_vec(0, 32'h1000_0000, DatA, 16'hFFFF, 4'h5, -1, -1, 0, 0, 1'b0, 9);
        add_wr(0, 32'h1000_0000, 32'h00000000, 4'hF);
        add_wr(0, 32'h1000_0004, 32'h11111111, 4'hF);
        add_wr(0, 32'h1000_0008, 32'h22222222, 4'hF);
        add_wr(0, 32'h1000_000C, 32'h33333333, 4'hF);

        set_vec(1, 32'h1000_0002, DatA, 16'hFFFF, 4'h3, -1, -1, 0, 0, 1'b1, 1);

        set_vec(2, 32'h2000_0000, DatB, 16'hFFFF, 4'h9, 1, -1, 0, 0, 1'b1, 5);
        add_wr(2, 32'h2000_0000, 32'hAAAAAAAA, 4'hF);
        add_wr(2, 32'h2000_0004, 32'hBBBBBBBB, 4'hF);

        set_vec(3, 32'h3000_0010, DatA, 16'hFFFF, 4'hA, -1, 2, 3, 2, 1'b0, 12);
        add_wr(3, 32'h3000_0010, 32'h00000000, 4'hF);
        add_wr(3, 32'h3000_0014, 32'h11111111, 4'hF);
        add_wr(3, 32'h3000_0018, 32'h22222222, 4'hF);
        add_wr(3, 32'h3000_001C, 32'h33333333, 4'hF);

`ifdef XADAC_VSTORE_BEAT_SKIP_EN
        set_vec(4, 32'h4000_0000, DatA, 16'h00F0, 4'h7, -1, -1, 0, 0, 1'b0, 3);
        add_wr(4, 32'h4000_0004, 32'h11111111, 4'hF);
        set_vec(7, 32'h0000_0200, DatA, 16'h0000, 4'h1, -1, -1, 0, 0, 1'b0, 1);
`else
        set_vec(4, 32'h4000_0000, DatA, 16'h0F0F, 4'h7, -1, -1, 0, 0, 1'b0, 9);
        add_wr(4, 32'h4000_0000, 32'h00000000, 4'hF);
        add_wr(4, 32'h4000_0004, 32'h11111111, 4'h0);
        add_wr(4, 32'h4000_0008, 32'h22222222, 4'hF);
        add_wr(4, 32'h4000_000C, 32'h33333333, 4'h0);
        set_vec(7, 32'h0000_0200, DatA, 16'h0000, 4'h1, -1, -1, 0, 0, 1'b0, 9);
        add_wr(7, 32'h0000_0200, 32'h00000000, 4'h0);
        add_wr(7, 32'h0000_0204, 32'h11111111, 4'h0);
        add_wr(7, 32'h0000_0208, 32'h22222222, 4'h0);
        add_wr(7, 32'h0000_020C, 32'h33333333, 4'h0);
`endif

        set_vec(5, 32'hFFFF_FFF8, DatA, 16'hFFFF, 4'hC, -1, -1, 0, 0, 1'b0, 9);
        add_wr(5, 32'hFFFF_FFF8, 32'h00000000, 4'hF);
        add_wr(5, 32'hFFFF_FFFC, 32'h11111111, 4'hF);
        add_wr(5, 32'h0000_0000, 32'h22222222, 4'hF);
        add_wr(5, 32'h0000_0004, 32'h33333333, 4'hF);

        set_vec(6, 32'h0000_0100, DatB, 16'h8421, 4'hF, -1, -1, 0, 0, 1'b0, 9);
        add_wr(6, 32'h0000_0100, 32'hAAAAAAAA, 4'h1);
        add_wr(6, 32'h0000_0104, 32'hBBBBBBBB, 4'h2);
        add_wr(6, 32'h0000_0108, 32'hCCCCCCCC, 4'h4);
        add_wr(6, 32'h0000_010C, 32'hDDDDDDDD, 4'h8);

        rst_i           = 1'b1;
        req_valid_i     = 1'b0;
        req_addr_i      = '0;
        req_data_i      = '0;
        req_mask_i      = '0;
        req_id_i        = '0;
        mem_req_ready_i = 1'b0;
        mem_ack_i       = 1'b0;
        mem_err_i       = 1'b0;
        rsp_ready_i     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_reset("por");

        for (int i = 0; i < NVec; i++) run_vec(i);

        // Reset while a write is outstanding, then a late ack.
        cur             = 100;
        req_valid_i     = 1'b1;
        req_addr_i      = 32'hFFFF_FFF8;
        req_data_i      = DatA;
        req_mask_i      = 16'hFFFF;
        req_id_i        = 4'h6;
        mem_req_ready_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        chk("mid_issue_valid", mem_req_valid_o, 1);
        chk("mid_issue_addr", mem_addr_o, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        chk("mid_wait_valid", mem_req_valid_o, 0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check_reset("mid_rst");
        mem_ack_i = 1'b1;
        mem_err_i = 1'b1;
        @(posedge clk);
        #1;
        mem_ack_i = 1'b0;
        mem_err_i = 1'b0;
        chk("late_ack_rsp", rsp_valid_o, 0);
        chk("late_ack_mem", mem_req_valid_o, 0);
        chk("late_ack_ready", req_ready_o, 1);
        run_vec(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
